// File: rtl/seg_pkg.sv
// Shared constants for the segment scan controller: register map defaults,
// CTRL field positions and the hex-to-segment table.
package seg_pkg;
  localparam logic [31:0] ADDR_DATA_DEF = 32'h4000_0014;
  localparam logic [31:0] ADDR_CTRL_DEF = 32'h4000_0018;

  localparam int CTRL_SCAN_EN  = 0;
  localparam int CTRL_BLANK_LSB = 4;
  localparam int CTRL_DP_LSB   = 8;

  // Segment codes {g,f,e,d,c,b,a}, entry 15 leftmost
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };
endpackage

// File: rtl/seg_decode.sv
// Hex nibble to 7-segment code (active-high, bit0 = a).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TAB[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped 4-digit multiplexed 7-segment scanner with per-digit blank
// and dp masks, and a dead cycle at the start of each slot against ghosting.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int          SCAN_DIV  = 50000,
  parameter logic [31:0] ADDR_DATA = ADDR_DATA_DEF,
  parameter logic [31:0] ADDR_CTRL = ADDR_CTRL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] data_in,
  output logic [31:0] rd_data,
  output logic [7:0]  leds,
  output logic [3:0]  enable
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   data_q;
  logic [11:0]   ctrl_q;
  logic [PW-1:0] presc, presc_n;
  logic [1:0]    idx, idx_n;
  logic          run, run_n;
  logic          scan_en;
  logic [3:0]    blank_mask, dp_mask;
  logic [6:0]    seg;

  assign scan_en    = ctrl_q[CTRL_SCAN_EN];
  assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 4];
  assign dp_mask    = ctrl_q[CTRL_DP_LSB +: 4];

  always_comb begin
    rd_data = 32'h0;
    if (Addr == ADDR_DATA)      rd_data = {16'h0, data_q};
    else if (Addr == ADDR_CTRL) rd_data = {20'h0, ctrl_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (MemWr) begin
      if (Addr == ADDR_DATA)      data_q <= data_in[15:0];
      else if (Addr == ADDR_CTRL) ctrl_q <= data_in[11:0];
    end
  end

  // Position of the slot counter for the cycle after the coming edge; the
  // first enabled edge only arms the scanner and opens digit 0's dead cycle.
  always_comb begin
    presc_n = '0;
    idx_n   = '0;
    run_n   = 1'b0;
    if (scan_en) begin
      run_n = 1'b1;
      if (run) begin
        idx_n = idx;
        if (presc == PRESC_LAST) begin
          idx_n = idx + 2'd1;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
    end
  end

  seg_decode u_dec (
    .nib (data_q[4*idx_n +: 4]),
    .seg (seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      idx    <= '0;
      run    <= 1'b0;
      leds   <= '0;
      enable <= '0;
    end else begin
      presc <= presc_n;
      idx   <= idx_n;
      run   <= run_n;
      if (!scan_en || blank_mask[idx_n]) begin
        leds   <= '0;
        enable <= '0;
      end else begin
        leds   <= {dp_mask[idx_n], seg};
        enable <= (presc_n == '0) ? 4'b0000 : (4'b0001 << idx_n);
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + random bench for seg_scan_ctrl against a time-indexed model.
module tb_seg_scan_ctrl;
  localparam int SD = 4;
  localparam logic [31:0] A_DATA  = 32'h4000_0014;
  localparam logic [31:0] A_CTRL  = 32'h4000_0018;
  localparam logic [31:0] A_OTHER = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWr;
  logic [31:0] Addr, data_in, rd_data;
  logic [7:0]  leds;
  logic [3:0]  enable;

  int passed = 0;
  int total  = 0;

  logic [15:0] m_data;
  logic [11:0] m_ctrl;
  int          t;
  logic [7:0]  e_led;
  logic [3:0]  e_en;
  logic [6:0]  seg_tab [16];

  seg_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .MemWr(MemWr), .Addr(Addr), .data_in(data_in),
    .rd_data(rd_data), .leds(leds), .enable(enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (a == A_DATA) return {16'h0, m_data};
    if (a == A_CTRL) return {20'h0, m_ctrl};
    return 32'h0;
  endfunction

  // One clock edge: expected outputs come from the register values seen
  // before the edge; the store then lands in the model.
  task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int pos, di, nib;
    MemWr = wr; Addr = a; data_in = d;
    @(posedge clk);
    if (!m_ctrl[0]) begin
      t = -1; e_led = 8'h0; e_en = 4'h0;
    end else begin
      t++;
      pos = t % SD;
      di  = (t / SD) % 4;
      nib = (m_data >> (4 * di)) & 15;
      if (m_ctrl[4 + di]) begin
        e_led = 8'h0; e_en = 4'h0;
      end else begin
        e_led = {m_ctrl[8 + di], seg_tab[nib]};
        e_en  = (pos == 0) ? 4'h0 : 4'(1 << di);
      end
    end
    if (wr && a == A_DATA) m_data = d[15:0];
    if (wr && a == A_CTRL) m_ctrl = d[11:0];
    #1;
    chk("enable", {28'h0, enable}, {28'h0, e_en});
    chk("leds", {24'h0, leds}, {24'h0, e_led});
    chk("rd_data", rd_data, m_rd(a));
    MemWr = 1'b0;
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) step(1'b0, a, 32'h0);
  endtask

  initial begin
    seg_tab = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
    m_data = 16'h0; m_ctrl = 12'h0; t = -1;
    rst = 1'b1; MemWr = 1'b0; Addr = A_CTRL; data_in = 32'h0;
    #12;
    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_enable", {28'h0, enable}, 32'h0);
    chk("rst_ctrl", rd_data, 32'h0);
    rst = 1'b0;
    idle(2, A_DATA);

    // 0x1234 scan: 66, 4f, 5b, 06 across digits 0..3
    step(1'b1, A_DATA, 32'hFFFF_1234);
    step(1'b1, A_CTRL, 32'h0000_0001);
    idle(2 * 4 * SD + 1, A_DATA);
    // digit1 blanked, 0xABCD
    step(1'b1, A_CTRL, 32'h0000_0021);
    step(1'b1, A_DATA, 32'h0000_ABCD);
    idle(4 * SD + 3, A_CTRL);
    // dp on digit0 with an 8 -> 0xFF
    step(1'b1, A_CTRL, 32'h0000_0101);
    step(1'b1, A_DATA, 32'h0000_0008);
    idle(4 * SD + 2, A_DATA);
    // store to an unmapped address
    step(1'b1, A_OTHER, 32'h0000_FFFF);
    idle(SD + 1, A_DATA);
    step(1'b0, A_CTRL, 32'h0);
    // DATA write landing on a terminal-count edge
    for (int i = 0; i < 2 * SD && (t % SD) != SD - 1; i++) step(1'b0, A_DATA, 32'h0);
    chk("tc_align", t % SD, SD - 1);
    step(1'b1, A_DATA, 32'h0000_5678);
    idle(SD + 1, A_DATA);
    // CTRL=0 turns the display off on the following edge
    step(1'b1, A_CTRL, 32'h0);
    idle(2, A_CTRL);

    // Reset mid-scan
    step(1'b1, A_CTRL, 32'h0000_0001);
    idle(SD + 2, A_DATA);
    chk("prereset_on", {31'h0, enable != 4'h0}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_leds", {24'h0, leds}, 32'h0);
    chk("async_enable", {28'h0, enable}, 32'h0);
    m_data = 16'h0; m_ctrl = 12'h0; t = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    Addr = A_CTRL; #1;
    chk("post_rst_ctrl", rd_data, 32'h0);
    idle(SD + 2, A_CTRL);

    // Random stores and reads
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic        wr;
      case ($urandom_range(0, 3))
        0: a = A_DATA;
        1: a = A_CTRL;
        2: a = A_OTHER;
        default: a = $urandom;
      endcase
      wr = ($urandom_range(0, 7) == 0);
      d  = $urandom;
      if (a == A_CTRL) d[0] = ($urandom_range(0, 3) != 0);
      step(wr, a, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
